custom_sequence_checker: RTL and testbench

Receive-side checker for the 9-state custom code sequence 0000→1001→1010→1100→0111→1101→0100→0101→0110→0000 produced by the team's custom counter.
- Decodes each incoming 4-bit code to its ordinal index (0..8).
- Locks onto the sequence and flags out-of-sequence and illegal codes.
- Keeps a saturating error count.
- Sits downstream of the counter (or a link carrying its code) as a health monitor.

---
 rtl/custom_seq_pkg.sv | 69 ++++++
 rtl/custom_seq_decode.sv | 18 +
 rtl/custom_sequence_checker.sv | 155 +++++++++++++++
 tb/tb_custom_sequence_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/custom_seq_pkg.sv
// Shared code table for the custom 9-state counter and its receive-side checker.
package custom_seq_pkg;

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SEQ_LEN = 9;

  localparam logic [CODE_W-1:0] CODE_0 = 4'b0000;
  localparam logic [CODE_W-1:0] CODE_1 = 4'b1001;
  localparam logic [CODE_W-1:0] CODE_2 = 4'b1010;
  localparam logic [CODE_W-1:0] CODE_3 = 4'b1100;
  localparam logic [CODE_W-1:0] CODE_4 = 4'b0111;
  localparam logic [CODE_W-1:0] CODE_5 = 4'b1101;
  localparam logic [CODE_W-1:0] CODE_6 = 4'b0100;
  localparam logic [CODE_W-1:0] CODE_7 = 4'b0101;
  localparam logic [CODE_W-1:0] CODE_8 = 4'b0110;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] idx;
  } seq_dec_t;

  // Code to ordinal; legal=0 for the seven codes outside the sequence.
  function automatic seq_dec_t code_to_idx(input logic [CODE_W-1:0] code);
    seq_dec_t d;
    d.legal = 1'b1;
    d.idx   = '0;
    case (code)
      CODE_0:  d.idx = IDX_W'(0);
      CODE_1:  d.idx = IDX_W'(1);
      CODE_2:  d.idx = IDX_W'(2);
      CODE_3:  d.idx = IDX_W'(3);
      CODE_4:  d.idx = IDX_W'(4);
      CODE_5:  d.idx = IDX_W'(5);
      CODE_6:  d.idx = IDX_W'(6);
      CODE_7:  d.idx = IDX_W'(7);
      CODE_8:  d.idx = IDX_W'(8);
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [CODE_W-1:0] idx_to_code(input logic [IDX_W-1:0] idx);
    logic [CODE_W-1:0] c;
    case (idx)
      IDX_W'(1): c = CODE_1;
      IDX_W'(2): c = CODE_2;
      IDX_W'(3): c = CODE_3;
      IDX_W'(4): c = CODE_4;
      IDX_W'(5): c = CODE_5;
      IDX_W'(6): c = CODE_6;
      IDX_W'(7): c = CODE_7;
      IDX_W'(8): c = CODE_8;
      default:   c = CODE_0;
    endcase
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] seq_next_idx(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(SEQ_LEN - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/custom_seq_decode.sv
// Pure combinational decoder from a received code to {legal, ordinal}.
module custom_seq_decode
  import custom_seq_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              legal_c,
  output logic [IDX_W-1:0]  idx_c
);

  seq_dec_t dec;

  always_comb begin
    dec     = code_to_idx(code);
    legal_c = dec.legal;
    idx_c   = dec.idx;
  end

endmodule

// File: rtl/custom_sequence_checker.sv
// Health monitor for the custom counter: locks onto the code sequence and
// flags out-of-sequence and illegal codes, with a saturating error count.
module custom_sequence_checker
  import custom_seq_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  input  logic              clear_err,
  output logic [IDX_W-1:0]  index_out,
  output logic              index_valid,
  output logic              locked,
  output logic              seq_error,
  output logic              illegal_code,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned MATCH_W = 4;

  seq_state_t         state, state_d;
  logic [IDX_W-1:0]   last_idx, last_idx_d;
  logic [MATCH_W-1:0] match_cnt, match_cnt_d;
  logic [IDX_W-1:0]   index_out_d;
  logic               index_valid_d;
  logic               locked_d;
  logic               seq_error_d;
  logic               illegal_code_d;
  logic               wrap_pulse_d;
  logic [ERR_W-1:0]   err_count_d;
  logic               err_inc;

  logic               dec_legal;
  logic [IDX_W-1:0]   dec_idx;
  logic               in_seq;

  custom_seq_decode u_decode (
    .code    (code_in),
    .legal_c (dec_legal),
    .idx_c   (dec_idx)
  );

  // A repeated code never matches, since the expectation always advances.
  assign in_seq = dec_legal && (code_in == idx_to_code(seq_next_idx(last_idx)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEARCH;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d        = state;
    last_idx_d     = last_idx;
    match_cnt_d    = match_cnt;
    index_out_d    = index_out;
    index_valid_d  = 1'b0;
    seq_error_d    = 1'b0;
    illegal_code_d = 1'b0;
    wrap_pulse_d   = 1'b0;
    err_inc        = 1'b0;

    if (code_valid) begin
      if (dec_legal) begin
        index_out_d   = dec_idx;
        index_valid_d = 1'b1;
        last_idx_d    = dec_idx;
      end else begin
        illegal_code_d = 1'b1;
      end

      case (state)
        SEARCH: begin
          if (dec_legal) begin
            match_cnt_d = MATCH_W'(1);
            state_d     = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (!dec_legal) begin
            match_cnt_d = '0;
            state_d     = SEARCH;
          end else if (in_seq) begin
            match_cnt_d = match_cnt + MATCH_W'(1);
            if (match_cnt_d >= MATCH_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end
          end else begin
            match_cnt_d = MATCH_W'(1);
          end
        end
        LOCKED: begin
          if (in_seq) begin
            wrap_pulse_d = (dec_idx == '0);
          end else begin
            seq_error_d = 1'b1;
            err_inc     = 1'b1;
            if (dec_legal) begin
              match_cnt_d = MATCH_W'(1);
              state_d     = ACQUIRE;
            end else begin
              match_cnt_d = '0;
              state_d     = SEARCH;
            end
          end
        end
        default: begin
          match_cnt_d = '0;
          state_d     = SEARCH;
        end
      endcase
    end

    // Clear beats a coincident increment; increment saturates at all-ones.
    err_count_d = err_count;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
      err_count_d = err_count + ERR_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_idx     <= '0;
      match_cnt    <= '0;
      index_out    <= '0;
      index_valid  <= 1'b0;
      locked       <= 1'b0;
      seq_error    <= 1'b0;
      illegal_code <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
    end else begin
      last_idx     <= last_idx_d;
      match_cnt    <= match_cnt_d;
      index_out    <= index_out_d;
      index_valid  <= index_valid_d;
      locked       <= locked_d;
      seq_error    <= seq_error_d;
      illegal_code <= illegal_code_d;
      wrap_pulse   <= wrap_pulse_d;
      err_count    <= err_count_d;
    end
  end

endmodule

// File: tb/tb_custom_sequence_checker.sv
// Directed bench for custom_sequence_checker; a second instance with a 2-bit
// error counter shares the stimulus to exercise saturation.
module tb_custom_sequence_checker;

  logic       clk;
  logic       reset_n;
  logic [3:0] code_in;
  logic       code_valid;
  logic       clear_err;

  logic [3:0] index_out;
  logic       index_valid, locked, seq_error, illegal_code, wrap_pulse;
  logic [7:0] err_count;

  logic [3:0] s_index_out;
  logic       s_index_valid, s_locked, s_seq_error, s_illegal_code, s_wrap_pulse;
  logic [1:0] s_err_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] seq_codes [9];
  int         cur;

  custom_sequence_checker #(.LOCK_COUNT(3), .ERR_W(8)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .clear_err    (clear_err),
    .index_out    (index_out),
    .index_valid  (index_valid),
    .locked       (locked),
    .seq_error    (seq_error),
    .illegal_code (illegal_code),
    .wrap_pulse   (wrap_pulse),
    .err_count    (err_count)
  );

  custom_sequence_checker #(.LOCK_COUNT(3), .ERR_W(2)) u_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .clear_err    (clear_err),
    .index_out    (s_index_out),
    .index_valid  (s_index_valid),
    .locked       (s_locked),
    .seq_error    (s_seq_error),
    .illegal_code (s_illegal_code),
    .wrap_pulse   (s_wrap_pulse),
    .err_count    (s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] c, input logic v, input logic clr);
    code_in    = c;
    code_valid = v;
    clear_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idx"},   32'(index_out), 32'd0);
    check({tag, "_ival"},  32'(index_valid), 32'd0);
    check({tag, "_lock"},  32'(locked), 32'd0);
    check({tag, "_serr"},  32'(seq_error), 32'd0);
    check({tag, "_ill"},   32'(illegal_code), 32'd0);
    check({tag, "_wrap"},  32'(wrap_pulse), 32'd0);
    check({tag, "_err"},   32'(err_count), 32'd0);
    check({tag, "_serrc"}, 32'(s_err_count), 32'd0);
  endtask

  initial begin
    seq_codes = '{4'b0000, 4'b1001, 4'b1010, 4'b1100, 4'b0111,
                  4'b1101, 4'b0100, 4'b0101, 4'b0110};
    reset_n    = 1'b0;
    code_in    = 4'b0000;
    code_valid = 1'b0;
    clear_err  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    #3 reset_n = 1'b1;

    // Two full loops, gap-free
    for (int i = 0; i < 18; i++) begin
      step(seq_codes[i % 9], 1'b1, 1'b0);
      check("run_idx",  32'(index_out), 32'(i % 9));
      check("run_ival", 32'(index_valid), 32'd1);
      check("run_lock", 32'(locked), (i >= 2) ? 32'd1 : 32'd0);
      check("run_wrap", 32'(wrap_pulse), (i == 9) ? 32'd1 : 32'd0);
      check("run_err",  32'(err_count), 32'd0);
    end

    // Skip 0111 after 1100 while locked
    for (int i = 0; i < 4; i++) step(seq_codes[i], 1'b1, 1'b0);
    check("skip_pre_lock", 32'(locked), 32'd1);
    step(4'b1101, 1'b1, 1'b0);
    check("skip_serr", 32'(seq_error), 32'd1);
    check("skip_err",  32'(err_count), 32'd1);
    check("skip_lock", 32'(locked), 32'd0);
    check("skip_idx",  32'(index_out), 32'd5);
    check("skip_ill",  32'(illegal_code), 32'd0);
    step(4'b0100, 1'b1, 1'b0);
    check("skip_acq_lock", 32'(locked), 32'd0);
    check("skip_acq_serr", 32'(seq_error), 32'd0);
    step(4'b0101, 1'b1, 1'b0);
    check("skip_relock", 32'(locked), 32'd1);
    check("skip_err2",   32'(err_count), 32'd1);

    // Idle cycle ignores code_in
    step(4'b1111, 1'b0, 1'b0);
    check("idle_ival", 32'(index_valid), 32'd0);
    check("idle_ill",  32'(illegal_code), 32'd0);
    check("idle_idx",  32'(index_out), 32'd7);
    check("idle_lock", 32'(locked), 32'd1);

    // Illegal code while locked
    step(4'b1111, 1'b1, 1'b0);
    check("ill_ill",  32'(illegal_code), 32'd1);
    check("ill_serr", 32'(seq_error), 32'd1);
    check("ill_ival", 32'(index_valid), 32'd0);
    check("ill_idx",  32'(index_out), 32'd7);
    check("ill_lock", 32'(locked), 32'd0);
    check("ill_err",  32'(err_count), 32'd2);
    check("ill_serrc", 32'(s_err_count), 32'd2);
    // From SEARCH, three fresh codes are needed
    step(seq_codes[8], 1'b1, 1'b0);
    check("srch_lock1", 32'(locked), 32'd0);
    step(seq_codes[0], 1'b1, 1'b0);
    check("srch_lock2", 32'(locked), 32'd0);
    check("srch_wrap",  32'(wrap_pulse), 32'd0);
    step(seq_codes[1], 1'b1, 1'b0);
    check("srch_lock3", 32'(locked), 32'd1);
    check("srch_err",   32'(err_count), 32'd2);

    // Saturation on the 2-bit instance
    step(4'b0000, 1'b0, 1'b1);
    check("clr_err",   32'(err_count), 32'd0);
    check("clr_serrc", 32'(s_err_count), 32'd0);
    cur = 1;
    for (int k = 1; k <= 5; k++) begin
      step(seq_codes[cur], 1'b1, 1'b0);
      check("sat_serr",  32'(seq_error), 32'd1);
      check("sat_err",   32'(err_count), 32'(k));
      check("sat_serrc", 32'(s_err_count), (k >= 3) ? 32'd3 : 32'(k));
      step(seq_codes[(cur + 1) % 9], 1'b1, 1'b0);
      step(seq_codes[(cur + 2) % 9], 1'b1, 1'b0);
      cur = (cur + 2) % 9;
      check("sat_relock", 32'(locked), 32'd1);
    end
    step(seq_codes[cur], 1'b1, 1'b1);
    check("satclr_serr",  32'(seq_error), 32'd1);
    check("satclr_err",   32'(err_count), 32'd0);
    check("satclr_serrc", 32'(s_err_count), 32'd0);

    // Gapped valid after a fresh reset
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    check_all_zero("rst2");
    for (int i = 0; i < 12; i++) begin
      step(seq_codes[i % 9], 1'b1, 1'b0);
      check("gap_idx",  32'(index_out), 32'(i % 9));
      check("gap_ival", 32'(index_valid), 32'd1);
      check("gap_lock", 32'(locked), (i >= 2) ? 32'd1 : 32'd0);
      check("gap_wrap", 32'(wrap_pulse), (i == 9) ? 32'd1 : 32'd0);
      for (int g = 0; g < 2; g++) begin
        step(4'b1111, 1'b0, 1'b0);
        check("gap_idle_ival", 32'(index_valid), 32'd0);
        check("gap_idle_idx",  32'(index_out), 32'(i % 9));
        check("gap_idle_lock", 32'(locked), (i >= 2) ? 32'd1 : 32'd0);
        check("gap_idle_ill",  32'(illegal_code), 32'd0);
      end
    end
    check("gap_err", 32'(err_count), 32'd0);

    // Mid-cycle asynchronous reset while locked
    step(seq_codes[3], 1'b1, 1'b0);
    check("arst_pre_lock", 32'(locked), 32'd1);
    check("arst_pre_ival", 32'(index_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #3 reset_n = 1'b1;
    step(seq_codes[4], 1'b1, 1'b0);
    check("relock1", 32'(locked), 32'd0);
    check("relock1_idx", 32'(index_out), 32'd4);
    step(seq_codes[5], 1'b1, 1'b0);
    check("relock2", 32'(locked), 32'd0);
    step(seq_codes[6], 1'b1, 1'b0);
    check("relock3", 32'(locked), 32'd1);
    check("relock_err", 32'(err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
